// File: rtl/axi_dma_upsizer.sv
// 32-bit to 64-bit AXI INCR burst upsizer for the SD card DMA master.
// One outstanding read and one outstanding write; the two paths are independent.
module axi_dma_upsizer #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  // 32-bit slave write side
  input  logic [AW-1:0] s_awaddr,
  input  logic [7:0]    s_awlen,
  input  logic          s_awvalid,
  output logic          s_awready,
  input  logic [31:0]   s_wdata,
  input  logic [3:0]    s_wstrb,
  input  logic          s_wlast,
  input  logic          s_wvalid,
  output logic          s_wready,
  output logic [1:0]    s_bresp,
  output logic          s_bvalid,
  input  logic          s_bready,
  // 32-bit slave read side
  input  logic [AW-1:0] s_araddr,
  input  logic [7:0]    s_arlen,
  input  logic          s_arvalid,
  output logic          s_arready,
  output logic [31:0]   s_rdata,
  output logic [1:0]    s_rresp,
  output logic          s_rlast,
  output logic          s_rvalid,
  input  logic          s_rready,
  // 64-bit master write side
  output logic [AW-1:0] m_awaddr,
  output logic [7:0]    m_awlen,
  output logic [2:0]    m_awsize,
  output logic [1:0]    m_awburst,
  output logic          m_awvalid,
  input  logic          m_awready,
  output logic [63:0]   m_wdata,
  output logic [7:0]    m_wstrb,
  output logic          m_wlast,
  output logic          m_wvalid,
  input  logic          m_wready,
  input  logic [1:0]    m_bresp,
  input  logic          m_bvalid,
  output logic          m_bready,
  // 64-bit master read side
  output logic [AW-1:0] m_araddr,
  output logic [7:0]    m_arlen,
  output logic [2:0]    m_arsize,
  output logic [1:0]    m_arburst,
  output logic          m_arvalid,
  input  logic          m_arready,
  input  logic [63:0]   m_rdata,
  input  logic [1:0]    m_rresp,
  input  logic          m_rlast,
  input  logic          m_rvalid,
  output logic          m_rready
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

  // Number of 64-bit beats minus one, given the start lane and the 32-bit length.
  function automatic logic [7:0] wide_len(input logic lane, input logic [7:0] len);
    logic [8:0] beats;
    beats = {8'd0, lane} + {1'b0, len} + 9'd2;
    beats = beats >> 1;
    return beats[7:0] - 8'd1;
  endfunction

  // Low address bits are implied by the 8-byte bus; completion is counted, not taken from m_rlast.
  logic unused_bits;
  assign unused_bits = ^{s_awaddr[1:0], s_araddr[1:0], m_rlast};

  // ---------------------------------------------------------------- write path
  wstate_t        w_state_reg, w_state_next;
  logic [AW-4:0]  aw_addr_reg;
  logic [7:0]     aw_len_reg;
  logic [7:0]     w_cnt_reg;
  logic           w_lane_reg;
  logic           w_pend_reg;
  logic           aw_fire, w_fire, mw_fire;

  assign aw_fire = s_awvalid && s_awready;
  assign w_fire  = s_wvalid && s_wready;
  assign mw_fire = m_wvalid && m_wready;

  assign m_awaddr  = {aw_addr_reg, 3'b000};
  assign m_awlen   = aw_len_reg;
  assign m_awsize  = 3'd3;
  assign m_awburst = 2'b01;

  always_ff @(posedge clk) begin
    if (rst) w_state_reg <= W_IDLE;
    else     w_state_reg <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state_reg;
    s_awready    = 1'b0;
    m_awvalid    = 1'b0;
    s_wready     = 1'b0;
    m_wvalid     = 1'b0;
    m_wlast      = 1'b0;
    m_bready     = 1'b0;
    s_bvalid     = 1'b0;
    s_bresp      = 2'b00;
    case (w_state_reg)
      W_IDLE: begin
        s_awready = !rst;
        if (s_awvalid && !rst) w_state_next = W_ADDR;
      end
      W_ADDR: begin
        m_awvalid = 1'b1;
        if (m_awready) w_state_next = W_DATA;
      end
      W_DATA: begin
        s_wready = !w_pend_reg;
        m_wvalid = w_pend_reg;
        m_wlast  = w_pend_reg && (w_cnt_reg == aw_len_reg);
        if (w_pend_reg && m_wready && (w_cnt_reg == aw_len_reg)) w_state_next = W_RESP;
      end
      W_RESP: begin
        m_bready = s_bready;
        s_bvalid = m_bvalid;
        s_bresp  = m_bresp;
        if (m_bvalid && s_bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_addr_reg <= '0;
      aw_len_reg  <= '0;
      w_cnt_reg   <= '0;
      w_lane_reg  <= 1'b0;
      w_pend_reg  <= 1'b0;
    end else begin
      if (aw_fire) begin
        aw_addr_reg <= s_awaddr[AW-1:3];
        aw_len_reg  <= wide_len(s_awaddr[2], s_awlen);
        w_lane_reg  <= s_awaddr[2];
      end
      if (m_awvalid && m_awready) w_cnt_reg <= '0;
      if (w_fire) begin
        w_lane_reg <= ~w_lane_reg;
        if (w_lane_reg || s_wlast) w_pend_reg <= 1'b1;
      end
      if (mw_fire) begin
        w_pend_reg <= 1'b0;
        w_cnt_reg  <= w_cnt_reg + 8'd1;
      end
    end
  end

  // Each half of the outgoing beat is cleared after issue so unfilled lanes carry no strobes.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_wlane
      localparam logic LANE = (gi == 1);
      logic [31:0] data_reg;
      logic [3:0]  strb_reg;
      always_ff @(posedge clk) begin
        if (rst || aw_fire || mw_fire) begin
          data_reg <= '0;
          strb_reg <= '0;
        end else if (w_fire && (w_lane_reg == LANE)) begin
          data_reg <= s_wdata;
          strb_reg <= s_wstrb;
        end
      end
      assign m_wdata[gi*32 +: 32] = data_reg;
      assign m_wstrb[gi*4 +: 4]   = strb_reg;
    end
  endgenerate

  // ----------------------------------------------------------------- read path
  rstate_t        r_state_reg, r_state_next;
  logic [AW-4:0]  ar_addr_reg;
  logic [7:0]     ar_len_reg;
  logic [7:0]     r_rem_reg;
  logic           r_lane_reg;
  logic           r_full_reg;
  logic [63:0]    r_hold_reg;
  logic [1:0]     r_resp_reg;

  assign m_araddr  = {ar_addr_reg, 3'b000};
  assign m_arlen   = ar_len_reg;
  assign m_arsize  = 3'd3;
  assign m_arburst = 2'b01;
  assign s_rdata   = r_lane_reg ? r_hold_reg[63:32] : r_hold_reg[31:0];
  assign s_rresp   = r_resp_reg;

  always_ff @(posedge clk) begin
    if (rst) r_state_reg <= R_IDLE;
    else     r_state_reg <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state_reg;
    s_arready    = 1'b0;
    m_arvalid    = 1'b0;
    m_rready     = 1'b0;
    s_rvalid     = 1'b0;
    s_rlast      = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        s_arready = !rst;
        if (s_arvalid && !rst) r_state_next = R_ADDR;
      end
      R_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) r_state_next = R_DATA;
      end
      R_DATA: begin
        m_rready = !r_full_reg;
        s_rvalid = r_full_reg;
        s_rlast  = r_full_reg && (r_rem_reg == 8'd0);
        if (r_full_reg && s_rready && (r_rem_reg == 8'd0)) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_addr_reg <= '0;
      ar_len_reg  <= '0;
      r_rem_reg   <= '0;
      r_lane_reg  <= 1'b0;
      r_full_reg  <= 1'b0;
      r_hold_reg  <= '0;
      r_resp_reg  <= '0;
    end else begin
      if (s_arvalid && s_arready) begin
        ar_addr_reg <= s_araddr[AW-1:3];
        ar_len_reg  <= wide_len(s_araddr[2], s_arlen);
        r_lane_reg  <= s_araddr[2];
        r_rem_reg   <= s_arlen;
      end
      if (m_rvalid && m_rready) begin
        r_hold_reg <= m_rdata;
        r_resp_reg <= m_rresp;
        r_full_reg <= 1'b1;
      end
      if (s_rvalid && s_rready) begin
        r_lane_reg <= ~r_lane_reg;
        r_rem_reg  <= r_rem_reg - 8'd1;
        if (r_lane_reg || (r_rem_reg == 8'd0)) r_full_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_dma_upsizer.sv
// Randomized bench for axi_dma_upsizer: reactive 64-bit memory slave plus a
// byte-addressed reference image that predicts every 32-bit beat and final memory.
module tb_axi_dma_upsizer;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
  logic [7:0]    s_awlen, s_arlen, m_awlen, m_arlen;
  logic          s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0]   s_wdata, s_rdata;
  logic [3:0]    s_wstrb;
  logic [1:0]    s_bresp, s_rresp, m_awburst, m_arburst, m_bresp, m_rresp;
  logic          s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [2:0]    m_awsize, m_arsize;
  logic          m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [63:0]   m_wdata, m_rdata;
  logic [7:0]    m_wstrb;
  logic          m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;

  axi_dma_upsizer #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] mem64 [2048];
  logic [7:0]  ref_bytes [16384];
  int          bresp_cfg = 0;
  bit          rerr_en = 1'b0;
  logic [1:0]  rresp_q [$];
  logic [63:0] mw_data_q [$];
  logic [7:0]  mw_strb_q [$];
  logic        mw_last_q [$];
  logic [31:0] last_wd [$];
  logic [AW-1:0] seen_awaddr, seen_araddr;
  logic [7:0]  seen_awlen, seen_arlen;
  logic [4:0]  seen_awmode, seen_armode;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'(a & 32'h3FFC);
    return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
  endfunction

  // Index of the last 8-byte word touched, relative to the first.
  function automatic int last64(input logic [31:0] a, input int len);
    logic [31:0] e;
    e = a + 32'(4*len + 3);
    return int'(e[31:3]) - int'(a[31:3]);
  endfunction

  // ---------------------------------------------------------- read slave
  initial begin
    bit ractive = 1'b0;
    bit rhold = 1'b0;
    int rword = 0, ridx = 0, rlen = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ractive = 0; rhold = 0; m_arready = 0; m_rvalid = 0;
      end else begin
        m_arready = !ractive && ($urandom_range(0, 2) != 0);
        if (ractive && !rhold && ($urandom_range(0, 3) != 0)) begin
          m_rdata = mem64[(rword + ridx) % 2048];
          m_rresp = (rerr_en && ($urandom_range(0, 3) == 0)) ? 2'b10 : 2'b00;
          m_rlast = (ridx == rlen);
          rhold = 1;
        end
        m_rvalid = rhold;
        #1;
        if (m_arvalid && m_arready) begin
          ractive = 1; rword = int'(m_araddr[13:3]); rlen = int'(m_arlen); ridx = 0;
          seen_araddr = m_araddr; seen_arlen = m_arlen; seen_armode = {m_arsize, m_arburst};
        end
        if (m_rvalid && m_rready) begin
          rresp_q.push_back(m_rresp);
          rhold = 0;
          ridx++;
          if (ridx > rlen) ractive = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------- write slave
  initial begin
    bit wactive = 1'b0;
    bit bpend = 1'b0;
    int wword = 0, widx = 0, idx;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wactive = 0; bpend = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
      end else begin
        m_awready = !wactive && !bpend && ($urandom_range(0, 2) != 0);
        m_wready  = wactive && ($urandom_range(0, 3) != 0);
        m_bvalid  = bpend;
        m_bresp   = 2'(bresp_cfg);
        #1;
        if (m_awvalid && m_awready) begin
          wactive = 1; wword = int'(m_awaddr[13:3]); widx = 0;
          seen_awaddr = m_awaddr; seen_awlen = m_awlen; seen_awmode = {m_awsize, m_awburst};
        end
        if (m_wvalid && m_wready) begin
          idx = (wword + widx) % 2048;
          for (int b = 0; b < 8; b++)
            if (m_wstrb[b]) mem64[idx][8*b +: 8] = m_wdata[8*b +: 8];
          mw_data_q.push_back(m_wdata);
          mw_strb_q.push_back(m_wstrb);
          mw_last_q.push_back(m_wlast);
          widx++;
          if (m_wlast) begin wactive = 0; bpend = 1; end
        end
        if (m_bvalid && m_bready) bpend = 0;
      end
    end
  end

  // ---------------------------------------------------------- burst drivers
  task automatic write_burst(input logic [31:0] addr, input int len, input bit full_strb, input int gap_pct);
    logic [31:0] wd [$];
    logic [3:0]  ws [$];
    logic [7:0]  exp_strb [$];
    logic [31:0] a;
    logic [63:0] refw;
    int n64, cnt, j, base;
    bit got;
    n64 = last64(addr, len) + 1;
    for (int i = 0; i < n64; i++) exp_strb.push_back(8'h00);
    for (int k = 0; k <= len; k++) begin
      wd.push_back($urandom);
      ws.push_back(full_strb ? 4'hF : 4'($urandom_range(0, 15)));
      a = addr + 32'(4*k);
      j = int'(a[31:3]) - int'(addr[31:3]);
      exp_strb[j] = exp_strb[j] | (8'(ws[k]) << (a[2] ? 4 : 0));
      for (int b = 0; b < 4; b++)
        if (ws[k][b]) ref_bytes[int'((a + 32'(b)) & 32'h3FFF)] = wd[k][8*b +: 8];
    end
    last_wd = wd;
    mw_data_q.delete(); mw_strb_q.delete(); mw_last_q.delete();

    @(negedge clk);
    s_awaddr = addr; s_awlen = 8'(len); s_awvalid = 1; #1;
    cnt = 0;
    while (!s_awready && cnt < 1000) begin @(negedge clk); #1; cnt++; end
    if (cnt >= 1000) begin checks++; errors++; $display("FAIL aw_timeout: s_awready never seen, addr=%h", addr); end
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      s_awvalid = 0;
      while ($urandom_range(0, 99) < gap_pct) begin s_wvalid = 0; @(negedge clk); end
      s_wdata = wd[k]; s_wstrb = ws[k]; s_wlast = (k == len); s_wvalid = 1; #1;
      cnt = 0;
      while (!s_wready && cnt < 1000) begin @(negedge clk); #1; cnt++; end
      if (cnt >= 1000) begin checks++; errors++; $display("FAIL w_timeout: beat %0d not accepted", k); break; end
    end
    @(negedge clk);
    s_wvalid = 0; s_wlast = 0;
    got = 0; cnt = 0;
    while (!got && cnt < 2000) begin
      s_bready = ($urandom_range(0, 1) == 1); #1;
      if (s_bvalid && s_bready) begin
        got = 1;
        checks++;
        if (s_bresp !== 2'(bresp_cfg)) begin errors++; $display("FAIL bresp: got %0d expected %0d", s_bresp, bresp_cfg); end
      end
      cnt++;
      @(negedge clk);
    end
    s_bready = 0;
    checks++;
    if (!got) begin errors++; $display("FAIL b_timeout: no write response, addr=%h", addr); end

    checks++;
    if (seen_awaddr !== {addr[31:3], 3'b000} || seen_awlen !== 8'(n64 - 1) || seen_awmode !== 5'b01101) begin
      errors++;
      $display("FAIL aw_fields: got addr=%h len=%0d mode=%b expected addr=%h len=%0d mode=01101",
               seen_awaddr, seen_awlen, seen_awmode, {addr[31:3], 3'b000}, n64 - 1);
    end
    checks++;
    if (mw_strb_q.size() != n64) begin
      errors++; $display("FAIL w_beats: got %0d 64-bit beats expected %0d", mw_strb_q.size(), n64);
    end else begin
      for (int i = 0; i < n64; i++) begin
        checks++;
        if (mw_strb_q[i] !== exp_strb[i] || mw_last_q[i] !== (i == n64 - 1)) begin
          errors++;
          $display("FAIL w_beat%0d: got strb=%h last=%b expected strb=%h last=%b",
                   i, mw_strb_q[i], mw_last_q[i], exp_strb[i], (i == n64 - 1));
        end
      end
    end
    for (int i = 0; i < n64; i++) begin
      base = int'(((addr[31:3] + 29'(i)) * 8) & 32'h3FFF);
      for (int b = 0; b < 8; b++) refw[8*b +: 8] = ref_bytes[base + b];
      checks++;
      if (mem64[base / 8] !== refw) begin
        errors++; $display("FAIL mem_word %h: got %h expected %h", base, mem64[base / 8], refw);
      end
    end
    $display("write addr=%h len=%0d beats64=%0d bresp=%0d", addr, len, n64, bresp_cfg);
  endtask

  task automatic read_burst(input logic [31:0] addr, input int len);
    int k, cnt, wi, n64;
    logic [31:0] exp;
    logic [1:0]  eresp;
    n64 = last64(addr, len) + 1;
    rresp_q.delete();
    @(negedge clk);
    s_araddr = addr; s_arlen = 8'(len); s_arvalid = 1; #1;
    cnt = 0;
    while (!s_arready && cnt < 1000) begin @(negedge clk); #1; cnt++; end
    if (cnt >= 1000) begin checks++; errors++; $display("FAIL ar_timeout: s_arready never seen, addr=%h", addr); end
    @(negedge clk);
    s_arvalid = 0;
    k = 0; cnt = 0;
    while (k <= len && cnt < 5000) begin
      s_rready = ($urandom_range(0, 3) != 0); #1;
      if (s_rvalid && s_rready) begin
        exp = ref_word(addr + 32'(4*k));
        wi = (int'(addr[2]) + k) >> 1;
        eresp = (wi < rresp_q.size()) ? rresp_q[wi] : 2'b11;
        checks++;
        if (s_rdata !== exp || s_rresp !== eresp || s_rlast !== (k == len)) begin
          errors++;
          $display("FAIL r_beat%0d: got data=%h resp=%0d last=%b expected data=%h resp=%0d last=%b",
                   k, s_rdata, s_rresp, s_rlast, exp, eresp, (k == len));
        end
        k++;
      end
      cnt++;
      @(negedge clk);
    end
    s_rready = 0; #1;
    checks++;
    if (k <= len) begin errors++; $display("FAIL r_timeout: got %0d beats expected %0d", k, len + 1); end
    checks++;
    if (s_rvalid !== 1'b0) begin errors++; $display("FAIL r_extra: s_rvalid=%b after final beat expected 0", s_rvalid); end
    checks++;
    if (seen_araddr !== {addr[31:3], 3'b000} || seen_arlen !== 8'(n64 - 1) || seen_armode !== 5'b01101) begin
      errors++;
      $display("FAIL ar_fields: got addr=%h len=%0d mode=%b expected addr=%h len=%0d mode=01101",
               seen_araddr, seen_arlen, seen_armode, {addr[31:3], 3'b000}, n64 - 1);
    end
    $display("read addr=%h len=%0d beats64=%0d", addr, len, n64);
  endtask

  // ---------------------------------------------------------- scenarios
  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast, m_awvalid, m_wvalid,
         m_wlast, m_bready, m_arvalid, m_rready} !== 12'd0) begin
      errors++;
      $display("FAIL reset_handshake: got %b expected 000000000000",
               {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast, m_awvalid, m_wvalid,
                m_wlast, m_bready, m_arvalid, m_rready});
    end
    checks++;
    if (m_awaddr !== 32'd0 || m_araddr !== 32'd0) begin
      errors++; $display("FAIL reset_addr: got aw=%h ar=%h expected 0", m_awaddr, m_araddr);
    end
    checks++;
    if ({m_awlen, m_arlen} !== 16'd0) begin
      errors++; $display("FAIL reset_len: got aw=%0d ar=%0d expected 0", m_awlen, m_arlen);
    end
    checks++;
    if (m_wdata !== 64'd0 || m_wstrb !== 8'd0 || s_rdata !== 32'd0) begin
      errors++; $display("FAIL reset_data: got wdata=%h wstrb=%h rdata=%h expected 0", m_wdata, m_wstrb, s_rdata);
    end
    @(negedge clk);
    rst = 0; #1;
    checks++;
    if ({s_awready, s_arready} !== 2'b11) begin
      errors++; $display("FAIL idle_ready: got %b expected 11", {s_awready, s_arready});
    end
  endtask

  task automatic test_aligned_read();
    rerr_en = 0;
    read_burst(32'h1000, 255);
  endtask

  task automatic test_unaligned_read();
    rerr_en = 0;
    read_burst(32'h1004, 2);
    rerr_en = 1;
    read_burst(32'h0404, 7);
    rerr_en = 0;
  endtask

  task automatic test_unaligned_write();
    bresp_cfg = 2;
    write_burst(32'h2004, 1, 1'b1, 0);
    checks++;
    if (mw_data_q.size() != 2) begin
      errors++; $display("FAIL uw_count: got %0d beats expected 2", mw_data_q.size());
    end else begin
      checks++;
      if (mw_strb_q[0] !== 8'hF0 || mw_data_q[0][63:32] !== last_wd[0]) begin
        errors++; $display("FAIL uw_beat0: got strb=%h hi=%h expected strb=f0 hi=%h", mw_strb_q[0], mw_data_q[0][63:32], last_wd[0]);
      end
      checks++;
      if (mw_strb_q[1] !== 8'h0F || mw_data_q[1][31:0] !== last_wd[1] || mw_last_q[1] !== 1'b1) begin
        errors++;
        $display("FAIL uw_beat1: got strb=%h lo=%h last=%b expected strb=0f lo=%h last=1",
                 mw_strb_q[1], mw_data_q[1][31:0], mw_last_q[1], last_wd[1]);
      end
    end
    bresp_cfg = 0;
  endtask

  task automatic test_single_write();
    bresp_cfg = 0;
    write_burst(32'h3000, 0, 1'b1, 0);
    checks++;
    if (mw_strb_q.size() != 1 || mw_strb_q[0] !== 8'h0F || mw_last_q[0] !== 1'b1 || seen_awlen !== 8'd0) begin
      errors++;
      $display("FAIL single_write: got beats=%0d awlen=%0d expected beats=1 strb=0f last=1 awlen=0",
               mw_strb_q.size(), seen_awlen);
    end
  endtask

  task automatic test_back_to_back();
    rerr_en = 1;
    for (int i = 0; i < 8; i++) begin
      bresp_cfg = (i % 3 == 0) ? 2 : 0;
      fork
        write_burst(32'h2000 + 32'(4 * $urandom_range(0, 255)), $urandom_range(0, 63), $urandom_range(0, 1) == 1, 30);
        read_burst(32'(4 * $urandom_range(0, 255)), $urandom_range(0, 63));
      join
    end
    write_burst(32'h2800, 15, 1'b1, 0);
    write_burst(32'h2844, 6, 1'b0, 0);
    rerr_en = 0;
    bresp_cfg = 0;
  endtask

  task automatic test_reset_mid_burst();
    int got = 0;
    int cnt = 0;
    @(negedge clk);
    s_araddr = 32'h1000; s_arlen = 8'd255; s_arvalid = 1; #1;
    while (!s_arready && cnt < 1000) begin @(negedge clk); #1; cnt++; end
    @(negedge clk);
    s_arvalid = 0; cnt = 0;
    while (got < 10 && cnt < 1000) begin
      s_rready = 1; #1;
      if (s_rvalid && s_rready) got++;
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (got != 10) begin errors++; $display("FAIL pre_reset_beats: got %0d expected 10", got); end
    rst = 1; s_rready = 0;
    @(negedge clk); #1;
    checks++;
    if ({m_arvalid, m_awvalid, m_wvalid, s_rvalid, s_bvalid, m_rready, s_arready, s_awready, s_wready} !== 9'd0) begin
      errors++;
      $display("FAIL mid_reset: got %b expected 000000000",
               {m_arvalid, m_awvalid, m_wvalid, s_rvalid, s_bvalid, m_rready, s_arready, s_awready, s_wready});
    end
    @(negedge clk);
    rst = 0;
    read_burst(32'h1008, 40);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1;
    s_awaddr = 0; s_awlen = 0; s_awvalid = 0;
    s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_wvalid = 0; s_bready = 0;
    s_araddr = 0; s_arlen = 0; s_arvalid = 0; s_rready = 0;
    for (int i = 0; i < 2048; i++) begin
      mem64[i] = {$urandom, $urandom};
      for (int b = 0; b < 8; b++) ref_bytes[i*8 + b] = mem64[i][8*b +: 8];
    end
    test_reset();
    test_aligned_read();
    test_unaligned_read();
    test_unaligned_write();
    test_single_write();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_dma_upsizer.md
Name: axi_dma_upsizer

Overview:
- Sits directly downstream of the SD card controller wrapper's AXI master port.
- Converts its 32-bit INCR bursts of up to 256 beats (1024 B) into 64-bit INCR bursts for the system memory interconnect.
- Handles one outstanding read and one outstanding write; the read and write paths run independently.
- Packs write data into 64-bit beats with byte strobes, unpacks read data into 32-bit beats, and forwards responses.

Parameters:
- AW, 32, address width on both sides.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_awaddr  in  AW  slave write address, 4-byte aligned
- s_awlen  in  8  slave write burst length minus 1
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_wdata  in  32  write data
- s_wstrb  in  4  write strobes
- s_wlast  in  1  last write beat
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_bresp  out  2  write response
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_araddr  in  AW  slave read address, 4-byte aligned
- s_arlen  in  8  slave read burst length minus 1
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- s_rlast  out  1  last read beat
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- m_awaddr / m_awlen(8) / m_awsize(3) / m_awburst(2) / m_awvalid  out, m_awready  in  64-bit write address channel
- m_wdata(64) / m_wstrb(8) / m_wlast / m_wvalid  out, m_wready  in  64-bit write data channel
- m_bresp(2) / m_bvalid  in, m_bready  out  64-bit write response channel
- m_araddr / m_arlen(8) / m_arsize(3) / m_arburst(2) / m_arvalid  out, m_arready  in  64-bit read address channel
- m_rdata(64) / m_rresp(2) / m_rlast / m_rvalid  in, m_rready  out  64-bit read data channel

Behaviour:
- Reset values: every valid/ready output is 0; all data, address and length registers are 0. Reset mid-burst drops the transaction silently; no response is generated.
- Constants:
  - m_awsize = m_arsize = 3.
  - m_awburst = m_arburst = 1 (INCR).
  - m_awaddr / m_araddr = captured address with bits [2:0] cleared.
- Output length: m_len = ((addr[2] + len + 1) + 1 >> 1) - 1, computed in 9 bits; the result always fits in 8 bits.
- Write FSM, states W_IDLE, W_ADDR, W_DATA, W_RESP:
  - W_IDLE: s_awready = 1. On s_awvalid, capture addr, lane = addr[2] and m_len, then go to W_ADDR.
  - W_ADDR: m_awvalid = 1 until m_awready, then go to W_DATA. The 64-bit beat counter is set to 0.
  - W_DATA packing:
    - Each accepted s_w beat is written into the buffer lane `lane`: bits [31:0] for lane 0, [63:32] for lane 1. Its s_wstrb goes to the matching 4 strobe bits.
    - lane then toggles.
  - W_DATA issue:
    - The 64-bit beat is issued (m_wvalid = 1) when lane 1 is filled or s_wlast is accepted.
    - s_wready = 0 while m_wvalid is pending.
    - Unfilled lanes carry strobe 0.
    - m_wlast = 1 when beat counter == m_len.
  - After the m_wlast handshake, go to W_RESP.
  - W_RESP: m_bready = s_bready; s_bvalid = m_bvalid; s_bresp = m_bresp. On the handshake, return to W_IDLE.
  - First beat with addr[2] = 1: low strobes are 0x0, giving m_wstrb = 0xF0 (when s_wstrb = 0xF).
- Read FSM, states R_IDLE, R_ADDR, R_DATA:
  - R_IDLE: s_arready = 1. On s_arvalid, capture addr, lane = addr[2], remaining = arlen and m_len, then go to R_ADDR.
  - R_ADDR: m_arvalid = 1 until m_arready, then go to R_DATA.
  - R_DATA unpacking:
    - A 64-bit beat is held in a register; m_rready = 1 only when the register is empty.
    - s_rdata = lane ? hold[63:32] : hold[31:0]; s_rresp = held rresp.
    - On each s_r handshake, lane toggles and remaining decrements.
    - The register empties when lane 1 is consumed or the last 32-bit beat is consumed.
  - s_rlast = (remaining == 0). After its handshake, return to R_IDLE.
  - Any m_rlast with remaining > 0 is ignored. The count governs completion.
- Latency: read path adds 1 cycle on address and 1 cycle on data. Write path adds 1 cycle on address and issues each data beat 1 cycle after its second half arrives.
- Simultaneous events:
  - Read and write FSMs are fully independent; both may be active in the same cycle.
  - An s_aw accept and an s_w beat in the same cycle is not allowed: s_wready = 0 outside W_DATA.
- Error handling: a non-OKAY m_rresp is propagated to both 32-bit halves of that beat.

Test Plan:
- Aligned read, araddr=0x1000, arlen=255 -> m_araddr=0x1000, m_arlen=127. 256 s_r beats ordered low then high half; s_rlast only on beat 255.
- Unaligned read, araddr=0x1004, arlen=2 -> m_araddr=0x1000, m_arlen=1. s_rdata sequence = hi(beat0), lo(beat1), hi(beat1); s_rlast on 3rd beat.
- Unaligned write, awaddr=0x2004, awlen=1, data A,B -> m_awlen=1. Beat0 = {A,x} with wstrb 0xF0; beat1 = {x,B} with wstrb 0x0F and m_wlast. s_bresp mirrors m_bresp = 2.
- Single-beat write, awaddr=0x3000, awlen=0 -> m_awlen=0, m_wstrb=0x0F, m_wlast=1.
- Backpressure: random m_wready/m_rready/s_rready stalls plus concurrent read and write bursts -> data order preserved, no beat lost or duplicated.
- Reset asserted mid read burst -> all valids 0 next cycle; a new burst then completes correctly.
